bus_arbiter8: RTL and testbench
===============================

Name: bus_arbiter8

Overview:
- Round-robin arbiter that shares one resource (the processor's shared data bus) among 8 requesters.
- It turns a 3-bit winner index into a registered one-hot grant, using 3-to-8 decoder semantics.
- It sits between the bus masters (fetch, load/store, DMA, I/O ports) and the bus mux select.
- It enforces fairness and a maximum hold time per grant.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant. 0 disables the timeout.
- CNT_W, 5, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  8  request vector; bit i high = requester i wants the bus. Level-held until done.
- gnt  output  8  registered one-hot grant; all zero when no owner.
- gnt_idx  output  3  binary index of the current owner; 0 when gnt_valid=0.
- gnt_valid  output  1  high while any grant bit is set (equals OR of gnt).
- timeout  output  1  one-cycle pulse, coincident with the first cycle after a forced release.

Behaviour:
- Reset (rst=1 at clk edge):
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - State IDLE, priority pointer ptr=0, hold_cnt=0.
  - Reset mid-grant removes gnt on that same edge; no handover occurs.
- States: IDLE (no owner), OWN (one owner, index cur).
- Winner search:
  - Circular scan starting at start index s over eligible requesters: first set bit of req in order s, s+1, ..., s+7 mod 8.
  - Pure combinational priority logic.
  - At most one gnt bit is ever set.
- IDLE:
  - If req != 0: winner w found with s=ptr. Next edge: gnt=1<<w, gnt_idx=w, gnt_valid=1, hold_cnt=1, state OWN.
  - Latency from req to gnt is 1 clock.
  - If req == 0: remain IDLE, outputs 0.
- OWN, normal release (req[cur]=0 at edge):
  - ptr <= cur+1 mod 8.
  - Search with s=cur+1, excluding cur.
  - If a winner is found, gnt switches directly to it on the same edge (zero-gap handover) and hold_cnt=1.
  - If no winner, gnt=0 and state IDLE.
- OWN, hold (req[cur]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD)):
  - gnt is unchanged.
  - hold_cnt increments, saturating at its max value when MAX_HOLD=0.
- OWN, forced release (req[cur]=1 and MAX_HOLD!=0 and hold_cnt==MAX_HOLD):
  - Same handover as normal release: ptr=cur+1, search excludes cur.
  - timeout=1 for exactly the next cycle.
  - A preempted requester that keeps req high becomes eligible again only at a later arbitration; it is then served in normal round-robin order.
- Grant duration: a requester is granted for at most MAX_HOLD consecutive cycles.
- Request changes:
  - Changes to non-owner req bits during OWN have no effect until the next arbitration.
  - New requests arriving in the same cycle as a release take part in that release's search.
- timeout is 0 in every cycle not immediately following a forced release.
- gnt, gnt_idx, gnt_valid and timeout are all registered; there are no combinational paths from req to outputs.

Test Plan:
- Single request:
  - After reset, req=8'h04 held for 3 cycles, then 0.
  - Required: gnt=8'h04 and gnt_idx=2 one edge after req rises, held 3 cycles, then gnt=0.
  - ptr=3 afterwards, so a subsequent req=8'h0C grants 3 before 2.
- Full contention:
  - req=8'hFF; each owner drops its own bit 2 cycles after its grant, then re-raises it.
  - Required grant order: 0,1,2,3,4,5,6,7,0 with no idle cycles between owners.
  - Exactly one gnt bit is set in every cycle.
- Handover:
  - Owner 7 with req=8'h81; drop bit 7.
  - Required: gnt goes 8'h80 -> 8'h01 on the next edge (wrap-around), gnt_valid stays 1 throughout.
- Timeout:
  - MAX_HOLD=4; req=8'h20 held indefinitely.
  - Required: gnt=8'h20 for exactly 4 cycles, then gnt=0 and timeout=1 for one cycle.
  - Next cycle: gnt=8'h20 again because it is the only requester.
  - Repeat with req=8'h60: required handover to 6 after 4 cycles, with timeout pulse.
- Reset mid-operation:
  - While owner 3 holds with req=8'h18, assert rst for 1 cycle.
  - Required: gnt=0, timeout=0 after the reset edge, ptr=0.
  - Next grant goes to requester 3 (the lowest set bit scanning from 0), 1 cycle after rst deasserts.
- Timeout disabled:
  - MAX_HOLD=0; req=8'h02 held for 40 cycles.
  - Required: gnt=8'h02 continuously, timeout never asserted, no counter-wrap release.

Source files
------------

// File: rtl/bus_arbiter8.sv
// bus_arbiter8: round-robin arbiter for 8 bus masters with registered one-hot grant
// and an optional per-grant hold limit that forces a handover.
module bus_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);
    typedef enum logic {IDLE, OWN} state_t;

    state_t           state, state_n;
    logic [2:0]       cur, cur_n, ptr, ptr_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic             to_n, forced, rel;
    logic [3:0]       idle_hit, rel_hit;

    // Returns {found, index} of the first set bit scanning r from s upward, wrapping.
    function automatic logic [3:0] find(input logic [7:0] r, input logic [2:0] s);
        logic [3:0] res;
        logic [2:0] k;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            k = s + 3'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    assign idle_hit = find(req, ptr);
    assign rel_hit  = find(req & ~(8'd1 << cur), cur + 3'd1);
    assign forced   = req[cur] && (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD));
    assign rel      = !req[cur] || forced;

    always_comb begin
        state_n = state;
        cur_n   = cur;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        to_n    = 1'b0;
        if (state == IDLE) begin
            if (idle_hit[3]) begin
                state_n = OWN;
                cur_n   = idle_hit[2:0];
                hold_n  = CNT_W'(1);
            end
        end else if (!rel) begin
            hold_n = (hold_cnt == '1) ? hold_cnt : hold_cnt + CNT_W'(1);
        end else begin
            ptr_n   = cur + 3'd1;
            to_n    = forced;
            state_n = rel_hit[3] ? OWN : IDLE;
            cur_n   = rel_hit[3] ? rel_hit[2:0] : cur;
            hold_n  = rel_hit[3] ? CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= 3'd0;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
            gnt       <= 8'd0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            gnt       <= (state_n == OWN) ? (8'd1 << cur_n) : 8'd0;
            gnt_idx   <= (state_n == OWN) ? cur_n : 3'd0;
            gnt_valid <= state_n == OWN;
            timeout   <= to_n;
        end
    end
endmodule

// File: tb/tb_bus_arbiter8.sv
// tb_bus_arbiter8: three arbiters (hold limit 16, 4, disabled) on one request bus,
// checked every cycle against an owner/pointer model plus literal scenario checks.
module tb_bus_arbiter8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'd0;
    logic [7:0] gnt_o [3];
    logic [2:0] idx_o [3];
    logic       val_o [3];
    logic       to_o  [3];
    int n_cmp = 0;
    int n_bad = 0;
    int mh [3] = '{16, 4, 0};
    int own [3];
    int ptr [3];
    int hc [3];
    int tom [3];
    int order [$];
    logic [7:0] prev;

    always #5 clk = ~clk;

    bus_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) u0 (.clk(clk), .rst(rst), .req(req),
        .gnt(gnt_o[0]), .gnt_idx(idx_o[0]), .gnt_valid(val_o[0]), .timeout(to_o[0]));
    bus_arbiter8 #(.MAX_HOLD(4), .CNT_W(5)) u1 (.clk(clk), .rst(rst), .req(req),
        .gnt(gnt_o[1]), .gnt_idx(idx_o[1]), .gnt_valid(val_o[1]), .timeout(to_o[1]));
    bus_arbiter8 #(.MAX_HOLD(0), .CNT_W(5)) u2 (.clk(clk), .rst(rst), .req(req),
        .gnt(gnt_o[2]), .gnt_idx(idx_o[2]), .gnt_valid(val_o[2]), .timeout(to_o[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [7:0] r, input int s, input int ex);
        for (int i = 0; i < 8; i++) begin
            int k;
            k = (s + i) % 8;
            if (r[k] && k != ex) return k;
        end
        return -1;
    endfunction

    // Model: who owns the bus, where the scan resumes, how long the owner has held it.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int w;
            if (rst) begin
                own[k] = -1; ptr[k] = 0; hc[k] = 0; tom[k] = 0;
            end else if (own[k] < 0) begin
                tom[k] = 0;
                w = search(req, ptr[k], -1);
                if (w >= 0) begin own[k] = w; hc[k] = 1; end
            end else if (req[own[k]] && (mh[k] == 0 || hc[k] < mh[k])) begin
                hc[k]++;
                tom[k] = 0;
            end else begin
                tom[k] = req[own[k]] ? 1 : 0;
                ptr[k] = (own[k] + 1) % 8;
                w = search(req, ptr[k], own[k]);
                own[k] = w;
                hc[k] = 1;
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] eg;
            logic [2:0] ei;
            eg = (own[k] >= 0) ? 8'(1 << own[k]) : 8'd0;
            ei = (own[k] >= 0) ? 3'(own[k]) : 3'd0;
            check($sformatf("model_u%0d", k), {19'd0, gnt_o[k], idx_o[k], val_o[k], to_o[k]},
                  {19'd0, eg, ei, own[k] >= 0, tom[k] != 0});
            check($sformatf("onehot_u%0d", k), 32'($countones(gnt_o[k]) <= 1), 32'd1);
        end
    end

    task automatic rst_cycle(input logic [7:0] r);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) begin rst = 1'b0; req = r; end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_gnt", gnt_o[0], 8'h00);
        check("reset_to", to_o[1], 1'b0);
        // single request, then pointer moves past 2
        @(negedge clk) req = 8'h04;
        @(posedge clk); #1;
        check("single_gnt", gnt_o[0], 8'h04);
        check("single_idx", idx_o[0], 3'd2);
        repeat (3) @(negedge clk);
        req = 8'h00;
        @(posedge clk); #1;
        check("single_rel", gnt_o[0], 8'h00);
        @(negedge clk) req = 8'h0C;
        @(posedge clk); #1;
        check("ptr_gnt", gnt_o[0], 8'h08);
        check("ptr_idx", idx_o[0], 3'd3);
        @(negedge clk) req = 8'h00;
        // wrap-around handover 7 -> 0
        @(negedge clk) req = 8'h80;
        @(posedge clk); #1;
        check("ho_own7", gnt_o[0], 8'h80);
        @(negedge clk) req = 8'h81;
        @(negedge clk) req = 8'h01;
        @(posedge clk); #1;
        check("ho_gnt", gnt_o[0], 8'h01);
        check("ho_valid", val_o[0], 1'b1);
        @(negedge clk) req = 8'h00;
        // timeout with a lone requester
        rst_cycle(8'h20);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("to_gnt", gnt_o[1], (i % 5 == 4) ? 8'h00 : 8'h20);
            check("to_pulse", to_o[1], i % 5 == 4);
        end
        rst_cycle(8'h60);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("to_ho_gnt", gnt_o[1], (i == 4) ? 8'h40 : 8'h20);
            check("to_ho_pulse", to_o[1], i == 4);
        end
        // reset in the middle of a grant
        rst_cycle(8'h18);
        @(posedge clk); #1;
        check("mid_own3", gnt_o[0], 8'h08);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_gnt", gnt_o[0], 8'h00);
        check("mid_rst_to", to_o[0], 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("mid_regrant", gnt_o[0], 8'h08);
        // hold limit disabled
        rst_cycle(8'h02);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check("nolimit_gnt", gnt_o[2], 8'h02);
            check("nolimit_to", to_o[2], 1'b0);
        end
        // full contention: each owner keeps the bus two cycles
        rst_cycle(8'hFF);
        prev = 8'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt_o[0] != 8'h00 && gnt_o[0] != prev) order.push_back(int'(idx_o[0]));
            req = (gnt_o[0] != 8'h00 && gnt_o[0] == prev) ? ~gnt_o[0] : 8'hFF;
            prev = gnt_o[0];
        end
        check("order_len", 32'(order.size() >= 9), 32'd1);
        for (int i = 0; i < 9 && i < order.size(); i++)
            check($sformatf("order_%0d", i), order[i], i % 8);
        // random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            req = req ^ (8'($urandom) & 8'($urandom));
            rst = $urandom_range(0, 59) == 0;
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
